// File: rtl/div32_seq.sv
`default_nettype none
// =============================================================================
// Module      : div32_seq
// Description : Iterative restoring divider for RV32M DIV/DIVU/REM/REMU.
//               It produces one quotient bit per clock, then applies one
//               sign-correction cycle.
// Revision    : 1.0 - initial release
// =============================================================================
module div32_seq #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [1:0]   op,
    input  logic [N-1:0] X,
    input  logic [N-1:0] Y,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] result
);

    localparam int                 c_CNT_W   = $clog2(N);
    localparam logic [c_CNT_W-1:0] c_LAST    = c_CNT_W'(N - 1);
    localparam logic [N-1:0]       c_MOST_NEG = {1'b1, {(N-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t               r_state;
    logic [N-1:0]         r_q;
    logic [N-1:0]         r_r;
    logic [N-1:0]         r_d;
    logic [c_CNT_W-1:0]   r_cnt;
    logic                 r_rem;
    logic                 r_sign_q;
    logic                 r_sign_r;
    logic                 r_special;

    logic                 w_x_neg;
    logic                 w_y_neg;
    logic [N-1:0]         w_abs_x;
    logic [N-1:0]         w_abs_y;
    logic                 w_div0;
    logic                 w_ovf;
    logic [N:0]           w_shift;
    logic [N+1:0]         w_diff;
    logic                 w_ge;

    assign w_x_neg = ~op[0] & X[N-1];
    assign w_y_neg = ~op[0] & Y[N-1];
    assign w_abs_x = w_x_neg ? -X : X;
    assign w_abs_y = w_y_neg ? -Y : Y;
    assign w_div0  = (Y == '0);
    assign w_ovf   = ~op[0] & (X == c_MOST_NEG) & (Y == '1);

    // The shifted partial remainder keeps its MSB so that divisors with
    // bit N-1 set still compare correctly; the borrow decides R' >= D.
    assign w_shift = {r_r, r_q[N-1]};
    assign w_diff  = {1'b0, w_shift} - {2'b00, r_d};
    assign w_ge    = ~w_diff[N+1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_q       <= '0;
            r_r       <= '0;
            r_d       <= '0;
            r_cnt     <= '0;
            r_rem     <= 1'b0;
            r_sign_q  <= 1'b0;
            r_sign_r  <= 1'b0;
            r_special <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            result    <= '0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_rem <= op[1];
                        r_cnt <= '0;
                        busy  <= 1'b1;
                        if (w_div0 || w_ovf) begin
                            // Final values are preloaded; FIX only publishes them.
                            r_special <= 1'b1;
                            r_sign_q  <= 1'b0;
                            r_sign_r  <= 1'b0;
                            r_d       <= Y;
                            r_q       <= w_div0 ? '1 : c_MOST_NEG;
                            r_r       <= w_div0 ? X  : '0;
                            r_state   <= S_FIX;
                        end else begin
                            r_special <= 1'b0;
                            r_sign_q  <= w_x_neg ^ w_y_neg;
                            r_sign_r  <= w_x_neg;
                            r_q       <= w_abs_x;
                            r_r       <= '0;
                            r_d       <= w_abs_y;
                            r_state   <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    r_r <= w_ge ? w_diff[N-1:0] : w_shift[N-1:0];
                    r_q <= {r_q[N-2:0], w_ge};
                    if (r_cnt == c_LAST) begin
                        r_state <= S_FIX;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_FIX: begin
                    if (r_rem) begin
                        result <= (r_sign_r && !r_special) ? -r_r : r_r;
                    end else begin
                        result <= (r_sign_q && !r_special) ? -r_q : r_q;
                    end
                    busy    <= 1'b0;
                    done    <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_div32_seq.sv
`default_nettype none
// =============================================================================
// Module      : tb_div32_seq
// Description : Self-checking bench for div32_seq; directed RV32M cases plus
//               randomized operations against an arithmetic reference.
// Revision    : 1.0 - initial release
// =============================================================================
module tb_div32_seq;

    logic        clk;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] X;
    logic [31:0] Y;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [1:0] c_DIV  = 2'b00;
    localparam logic [1:0] c_DIVU = 2'b01;
    localparam logic [1:0] c_REM  = 2'b10;
    localparam logic [1:0] c_REMU = 2'b11;

    div32_seq #(.N(32)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .X      (X),
        .Y      (Y),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // RISC-V semantics straight from the ISA rules, using native arithmetic.
    function automatic logic [31:0] ref_model(input logic [1:0] o, input logic [31:0] x,
                                              input logic [31:0] y);
        int sx;
        int sy;
        if (y == 32'd0) return o[1] ? x : 32'hFFFF_FFFF;
        if (!o[0]) begin
            if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF)
                return o[1] ? 32'd0 : 32'h8000_0000;
            sx = x;
            sy = y;
            return o[1] ? 32'(sx % sy) : 32'(sx / sy);
        end
        return o[1] ? (x % y) : (x / y);
    endfunction

    function automatic int ref_latency(input logic [1:0] o, input logic [31:0] x,
                                       input logic [31:0] y);
        if (y == 32'd0) return 2;
        if (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 2;
        return 34;
    endfunction

    // Called just after a clock edge; start is seen by the next edge (edge 0).
    // Latency counts edges from edge 0 up to and including the done edge.
    task automatic do_op(input string tag, input logic [1:0] o, input logic [31:0] x,
                         input logic [31:0] y, input int poke_at);
        logic [31:0] exp;
        int          lat;
        int          bcnt;
        exp   = ref_model(o, x, y);
        start = 1'b1;
        op    = o;
        X     = x;
        Y     = y;
        @(posedge clk); #1;
        start = 1'b0;
        X     = $urandom;
        Y     = $urandom;
        op    = 2'($urandom);
        lat   = 1;
        bcnt  = 0;
        while (!done && lat < 200) begin
            if (busy) bcnt++;
            if (lat == poke_at) begin
                start = 1'b1;
                op    = ~o;
                X     = $urandom;
                Y     = 32'd0;
            end
            @(posedge clk); #1;
            start = 1'b0;
            lat++;
        end
        check({tag, "_result"}, result, exp);
        check({tag, "_latency"}, 32'(lat), 32'(ref_latency(o, x, y)));
        check({tag, "_busy"}, 32'(bcnt), 32'(ref_latency(o, x, y) - 1));
    endtask

    task automatic idle_gap(input string tag, input int gap);
        logic [31:0] held;
        held = result;
        if (gap > 0) begin
            @(posedge clk); #1;
            check({tag, "_done_pulse"}, 32'(done), 32'd0);
            check({tag, "_hold"}, result, held);
            repeat (gap - 1) begin
                @(posedge clk); #1;
            end
        end
    endtask

    initial begin
        logic [1:0]  ro;
        logic [31:0] rx;
        logic [31:0] ry;
        int          dcnt;
        int          sel;

        reset = 1'b1;
        start = 1'b0;
        op    = 2'b00;
        X     = 32'd0;
        Y     = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_result", result, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;

        do_op("divu_100_7", c_DIVU, 32'd100, 32'd7, -1);
        idle_gap("g0", 2);
        do_op("remu_100_7", c_REMU, 32'd100, 32'd7, -1);
        idle_gap("g1", 1);
        do_op("div_m7_2", c_DIV, 32'hFFFF_FFF9, 32'd2, -1);
        do_op("rem_m7_2", c_REM, 32'hFFFF_FFF9, 32'd2, -1);
        do_op("rem_7_m2", c_REM, 32'd7, 32'hFFFF_FFFE, -1);
        do_op("divu_by0", c_DIVU, 32'h0000_1234, 32'd0, -1);
        do_op("rem_m5_by0", c_REM, 32'hFFFF_FFFB, 32'd0, -1);
        do_op("div_ovf", c_DIV, 32'h8000_0000, 32'hFFFF_FFFF, -1);
        do_op("rem_ovf", c_REM, 32'h8000_0000, 32'hFFFF_FFFF, -1);
        idle_gap("g2", 1);
        do_op("divu_poke", c_DIVU, 32'd1000, 32'd9, 10);
        idle_gap("g3", 3);
        do_op("divu_bigdiv", c_DIVU, 32'hFFFF_FFFE, 32'hC000_0001, -1);
        do_op("remu_bigdiv", c_REMU, 32'hFFFF_FFFE, 32'hC000_0001, -1);

        for (int i = 0; i < 40; i++) begin
            ro  = 2'($urandom);
            rx  = $urandom;
            ry  = $urandom;
            sel = $urandom_range(0, 9);
            if (sel == 0) ry = 32'd0;
            else if (sel == 1) begin rx = 32'h8000_0000; ry = 32'hFFFF_FFFF; end
            else if (sel < 5) ry = 32'($urandom_range(1, 300)) ^ {32{ry[31]}};
            do_op($sformatf("rnd%0d", i), ro, rx, ry, -1);
            idle_gap($sformatf("rgap%0d", i), $urandom_range(0, 2));
        end

        // Asynchronous abort mid-CALC: outputs clear before the next edge.
        do_op("divu_pre_rst", c_DIVU, 32'd100, 32'd7, -1);
        start = 1'b1;
        op    = c_DIVU;
        X     = 32'd5000;
        Y     = 32'd3;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_result", result, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        dcnt  = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) dcnt++;
        end
        check("abort_no_done", 32'(dcnt), 32'd0);
        do_op("divu_after_rst", c_DIVU, 32'hFFFF_FFFF, 32'd1, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
